// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between decode/execute/hazard control (master) and the
// PC sequencer (slave).
interface pc_sequencer_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        annul;
  logic        trap_req;
  logic [7:0]  trap_vec;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic [31:0] PC4;
  logic        fetch_valid;
  logic        trap_ack;
  logic        misalign;

  modport master (
    output stall, br_taken, br_target, annul, trap_req, trap_vec,
    input  PC, nPC, PC4, fetch_valid, trap_ack, misalign
  );

  modport slave (
    input  stall, br_taken, br_target, annul, trap_req, trap_vec,
    output PC, nPC, PC4, fetch_valid, trap_ack, misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC/nPC sequencer with delayed branches, annulled delay slots, stalls and trap entry.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned branch targets into trap 8'h07.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_BASE = 32'h0000_0100
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        fv_q, fv_d;
  logic        ack_q, ack_d;
  logic        align_fault;
  logic        take_trap;
  logic [7:0]  vec;
  logic [31:0] trap_pc;

  function automatic logic [31:0] trap_entry(input logic [7:0] v);
    return TRAP_BASE + {20'h0_0000, v, 4'b0000};
  endfunction

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  // A branch that would otherwise be taken this cycle but targets a non-word address.
  assign align_fault = (state_q == RUN) && !bus.trap_req && !bus.stall &&
                       bus.br_taken && (bus.br_target[1:0] != 2'b00);
  assign mis_d       = align_fault;

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign bus.misalign = mis_q;
`else
  assign align_fault  = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  assign take_trap = bus.trap_req || align_fault;
  assign vec       = bus.trap_req ? bus.trap_vec : 8'h07;
  assign trap_pc   = trap_entry(vec);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    fv_d    = fv_q;
    ack_d   = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        fv_d    = 1'b1;
      end
      RUN: begin
        if (take_trap) begin
          pc_d    = trap_pc;
          npc_d   = trap_pc + 32'd4;
          fv_d    = 1'b0;
          ack_d   = 1'b1;
          state_d = TRAP;
        end else if (bus.stall) begin
          state_d = RUN;
        end else if (bus.br_taken) begin
          // Delay slot at nPC still issues unless annulled.
          pc_d  = npc_q;
          npc_d = bus.br_target & ~32'h0000_0003;
          fv_d  = !bus.annul;
        end else begin
          pc_d  = npc_q;
          npc_d = npc_q + 32'd4;
          fv_d  = 1'b1;
        end
      end
      TRAP: begin
        fv_d    = 1'b1;
        state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      fv_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      fv_q    <= fv_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.nPC         = npc_q;
  assign bus.PC4         = pc_q + 32'd4;
  assign bus.fetch_valid = fv_q;
  assign bus.trap_ack    = ack_q;

endmodule
